// File: rtl/fsm_cpu_if.sv
// fsm_cpu_if: request/acknowledge link between the CPU-side sender and a
// peripheral receiver running on an unrelated clock.
//   ACK      peripheral -> CPU  acknowledge, asynchronous to the CPU clock
//   outDATA  CPU -> peripheral  data word, valid while outSEND is high
//   outSEND  CPU -> peripheral  request strobe (4-phase, return-to-zero)
interface fsm_cpu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ACK;
  logic [DATA_WIDTH-1:0] outDATA;
  logic                  outSEND;

  // CPU-side sender
  modport master (input ACK, output outDATA, output outSEND);
  // peripheral-side receiver
  modport slave (output ACK, input outDATA, input outSEND);
endinterface

// File: rtl/fsm_cpu.sv
// fsm_cpu: CPU-side sender of a 4-phase request/acknowledge link. Pushes an
// incrementing stream of words (DATA_INIT, DATA_INIT+DATA_STEP, ...) to a
// peripheral on another clock. One word per completed handshake.
// Ports:
//   clk  CPU clock, rising edge
//   rst  synchronous active-high reset
//   bus  fsm_cpu_if.master: ACK in (async), outDATA/outSEND out (registered)
module fsm_cpu #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DATA_INIT   = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] DATA_STEP   = DATA_WIDTH'(1)
) (
  input  logic       clk,
  input  logic       rst,
  fsm_cpu_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_NACK = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q,  data_d;
  logic                    send_q,  send_d;
  logic [DATA_WIDTH-1:0]   word_q,  word_d;
  logic [SYNC_STAGES-1:0]  sync_q,  sync_d;
  logic                    ack_s;

  // ACK synchronizer: shift register, oldest sample is the one the FSM uses.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.ACK};
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    send_d  = send_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        send_d = 1'b0;
        // Only launch once the previous handshake has fully released.
        if (!ack_s) begin
          data_d  = word_q;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // outDATA got a full cycle of setup; now raise the request.
        send_d  = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        send_d = 1'b1;
        if (ack_s) begin
          send_d  = 1'b0;
          state_d = WAIT_NACK;
        end
      end
      WAIT_NACK: begin
        send_d = 1'b0;
        // Handshake complete only once ACK returns to zero.
        if (!ack_s) begin
          word_d  = word_q + DATA_STEP;
          state_d = IDLE;
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // The synchronizer keeps sampling through reset so that ack_s already
    // reflects a stuck-high ACK on the first edge after release; otherwise
    // the FSM would launch a word the peripheral then sees acknowledged.
    // With ACK low for SYNC_STAGES reset cycles every flop here reads 0.
    sync_q <= sync_d;
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      send_q  <= 1'b0;
      word_q  <= DATA_INIT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      send_q  <= send_d;
      word_q  <= word_d;
    end
  end

  assign bus.outDATA = data_q;
  assign bus.outSEND = send_q;

endmodule

// File: tb/tb_fsm_cpu.sv
module tb_fsm_cpu;
  logic clk, pclk, rst;
  logic tb_ack, tb_ack_w, p_ack, p_en;
  int   errors, checks;

  fsm_cpu_if #(.DATA_WIDTH(32)) bus ();
  fsm_cpu_if #(.DATA_WIDTH(32)) bus_w ();

  assign bus.ACK   = p_en ? p_ack : tb_ack;
  assign bus_w.ACK = tb_ack_w;

  fsm_cpu #(.DATA_WIDTH(32), .SYNC_STAGES(2),
            .DATA_INIT(32'h0000_0001), .DATA_STEP(32'h0000_0001))
    dut (.clk(clk), .rst(rst), .bus(bus));

  fsm_cpu #(.DATA_WIDTH(32), .SYNC_STAGES(2),
            .DATA_INIT(32'hFFFF_FFFF), .DATA_STEP(32'h0000_0001))
    dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  // CPU clock posedges at 5+10j, peripheral posedges at 4+14k: never coincide.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    pclk = 1'b0;
    #4;
    forever begin
      pclk = 1'b1; #7;
      pclk = 1'b0; #7;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; tb_ack = 1'b0; tb_ack_w = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus.outSEND !== 1'b0) begin errors++; $display("FAIL reset_send: got %b want 0", bus.outSEND); end
    checks++; if (bus.outDATA !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", bus.outDATA); end
    checks++; if (bus_w.outDATA !== 32'h0) begin errors++; $display("FAIL reset_data_w: got %h want 00000000", bus_w.outDATA); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.outDATA !== 32'h1) begin errors++; $display("FAIL edge1_data: got %h want 00000001", bus.outDATA); end
    checks++; if (bus.outSEND !== 1'b0) begin errors++; $display("FAIL edge1_send: got %b want 0", bus.outSEND); end
    @(negedge clk);
    checks++; if (bus.outSEND !== 1'b1) begin errors++; $display("FAIL edge2_send: got %b want 1", bus.outSEND); end
    checks++; if (bus.outDATA !== 32'h1) begin errors++; $display("FAIL edge2_data: got %h want 00000001", bus.outDATA); end
  endtask

  // Peripheral model on the CPU clock: ACK 3 cycles after SEND, drop 3 after release.
  task automatic test_single();
    int n;
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.outSEND !== 1'b1 || bus.outDATA !== 32'h1) begin
        errors++; $display("FAIL single_hold: got send=%b data=%h want send=1 data=00000001", bus.outSEND, bus.outDATA);
      end
    end
    tb_ack = 1'b1;
    n = 0;
    while (bus.outSEND === 1'b1 && n < 10) begin
      @(negedge clk); n++;
      checks++; if (bus.outDATA !== 32'h1) begin errors++; $display("FAIL single_data_ack: got %h want 00000001", bus.outDATA); end
    end
    checks++; if (n < 2 || n > 3) begin errors++; $display("FAIL single_send_fall: got %0d cycles want 2..3", n); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.outSEND !== 1'b0 || bus.outDATA !== 32'h1) begin
        errors++; $display("FAIL single_nack_hold: got send=%b data=%h want send=0 data=00000001", bus.outSEND, bus.outDATA);
      end
    end
    tb_ack = 1'b0;
    n = 0;
    while (bus.outSEND !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n != 5) begin errors++; $display("FAIL single_next_rise: got %0d cycles want 5", n); end
    checks++; if (bus.outDATA !== 32'h2) begin errors++; $display("FAIL single_next_data: got %h want 00000002", bus.outDATA); end
  endtask

  // Enters in WAIT_ACK carrying word 2; reset must drop it and restart at 1.
  task automatic test_reset_mid();
    checks++; if (bus.outSEND !== 1'b1 || bus.outDATA !== 32'h2) begin
      errors++; $display("FAIL mid_pre: got send=%b data=%h want send=1 data=00000002", bus.outSEND, bus.outDATA);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.outSEND !== 1'b0) begin errors++; $display("FAIL mid_send: got %b want 0", bus.outSEND); end
    checks++; if (bus.outDATA !== 32'h0) begin errors++; $display("FAIL mid_data: got %h want 00000000", bus.outDATA); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.outDATA !== 32'h1) begin errors++; $display("FAIL mid_restart_data: got %h want 00000001", bus.outDATA); end
    @(negedge clk);
    checks++; if (bus.outSEND !== 1'b1) begin errors++; $display("FAIL mid_restart_send: got %b want 1", bus.outSEND); end
  endtask

  // Receiver on its own clock (period 14) for 10 handshakes.
  task automatic test_back_to_back();
    logic [31:0] got;
    int n;
    rst = 1'b1; tb_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    p_ack = 1'b0; p_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (bus.outSEND !== 1'b1 && n < 60) begin @(posedge pclk); n++; end
      checks++; if (n >= 60) begin errors++; $display("FAIL b2b_rise_timeout: word %0d got no request want request", i); break; end
      got = bus.outDATA;
      checks++; if (got !== 32'(i + 1)) begin errors++; $display("FAIL b2b_word: got %h want %h", got, 32'(i + 1)); end
      @(posedge pclk);
      p_ack = 1'b1;
      n = 0;
      while (bus.outSEND === 1'b1 && n < 60) begin
        checks++; if (bus.outDATA !== got) begin errors++; $display("FAIL b2b_stable: got %h want %h", bus.outDATA, got); end
        @(posedge pclk); n++;
      end
      checks++; if (n >= 60) begin errors++; $display("FAIL b2b_fall_timeout: word %0d send stuck high want low", i); break; end
      checks++; if (bus.outDATA !== got) begin errors++; $display("FAIL b2b_nack_hold: got %h want %h", bus.outDATA, got); end
      @(posedge pclk);
      p_ack = 1'b0;
    end
    @(negedge clk);
    p_en = 1'b0;
  endtask

  task automatic test_ack_stuck();
    int n;
    tb_ack = 1'b1; rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++; if (bus.outSEND !== 1'b0 || bus.outDATA !== 32'h0) begin
        errors++; $display("FAIL stuck_idle: got send=%b data=%h want send=0 data=00000000", bus.outSEND, bus.outDATA);
      end
    end
    tb_ack = 1'b0;
    n = 0;
    while (bus.outSEND !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL stuck_rise: got %0d cycles want 4", n); end
    checks++; if (bus.outDATA !== 32'h1) begin errors++; $display("FAIL stuck_data: got %h want 00000001", bus.outDATA); end
  endtask

  task automatic test_wrap();
    int n;
    tb_ack_w = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_w.outSEND !== 1'b1 || bus_w.outDATA !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_first: got send=%b data=%h want send=1 data=ffffffff", bus_w.outSEND, bus_w.outDATA);
    end
    tb_ack_w = 1'b1;
    n = 0;
    while (bus_w.outSEND === 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (bus_w.outSEND !== 1'b0) begin errors++; $display("FAIL wrap_fall: got %b want 0", bus_w.outSEND); end
    tb_ack_w = 1'b0;
    n = 0;
    while (bus_w.outSEND !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (bus_w.outSEND !== 1'b1) begin errors++; $display("FAIL wrap_rise: got %b want 1", bus_w.outSEND); end
    checks++; if (bus_w.outDATA !== 32'h0) begin errors++; $display("FAIL wrap_second: got %h want 00000000", bus_w.outDATA); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; tb_ack = 1'b0; tb_ack_w = 1'b0; p_ack = 1'b0; p_en = 1'b0;
    test_reset();
    test_single();
    test_reset_mid();
    test_back_to_back();
    test_ack_stuck();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
